// File: rtl/instr_prefetch_queue_if.sv
// Instruction-memory port and decode-facing port of the prefetch queue.
// The queue drives the master side; memory and decode sit on the slave side.
interface instr_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_rdata;

    logic              stall;
    logic              redirect;
    logic [31:0]       target;

    logic [31:0]       instr;
    logic [31:0]       pc_plus_four;
    logic              instr_valid;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  redirect,
        input  target,
        output instr,
        output pc_plus_four,
        output instr_valid,
        output occupancy
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output stall,
        output redirect,
        output target,
        input  instr,
        input  pc_plus_four,
        input  instr_valid,
        input  occupancy
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Fetch-side prefetch queue: issues sequential reads to a one-cycle synchronous
// instruction memory, buffers up to DEPTH words and presents the head to decode.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h5400_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_prefetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_four;
    } entry_t;

    logic [31:0]      fetch_pc_q,    fetch_pc_d;
    logic             inflight_q,    inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [CNT_W-1:0] count_q,       count_d;
    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];

    logic             credit_ok;
    logic             issue;
    logic [31:0]      issue_addr;
    logic             push;
    logic             pop;
    logic             not_empty;
    entry_t           head;

    // Credits count both stored entries and the word still coming back, so a
    // response can never find the queue full.
    always_comb begin
        not_empty  = (count_q != '0);
        credit_ok  = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
        issue      = credit_ok | bus.redirect;
        issue_addr = bus.redirect ? bus.target : fetch_pc_q;
        push       = inflight_q & ~bus.redirect;
        pop        = not_empty & ~bus.stall & ~bus.redirect;
        head       = entries_q[rd_ptr_q];
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        entries_d     = entries_q;

        if (issue) begin
            inflight_pc_d = issue_addr;
            fetch_pc_d    = issue_addr + 32'd4;
        end

        // A redirect discards both the queue and the response now returning.
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                entries_d[wr_ptr_q] = '{instr: bus.imem_rdata,
                                        pc_plus_four: inflight_pc_q + 32'd4};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Outputs are gated by rst_n so they take their idle values the moment
    // reset asserts, not at the next clock.
    assign bus.imem_req     = rst_n & issue;
    assign bus.imem_addr    = issue_addr;
    assign bus.instr_valid  = not_empty;
    assign bus.occupancy    = count_q;
    assign bus.instr        = not_empty ? head.instr : NOP_INSTR;
    assign bus.pc_plus_four = !rst_n    ? 32'h0 :
                              not_empty ? head.pc_plus_four : fetch_pc_q;

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) push |-> (count_q < CNT_W'(DEPTH))
    );

    a_count_bounded : assert property (
        @(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH)
    );
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a queue-based reference model checked
// every cycle, plus hand-computed expectations at the interesting cycles.
module tb_instr_prefetch_queue;
    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] NOP_INSTR = 32'h5400_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int   total;
    int   bad;

    instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus  ();
    instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus2 ();

    instr_prefetch_queue #(
        .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    instr_prefetch_queue #(
        .DEPTH(DEPTH), .RESET_PC(RESET_PC2), .NOP_INSTR(NOP_INSTR)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    // Synchronous memory: data for a request appears on the following cycle
    // and is held while no new request is made.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= memWord(bus.imem_addr);
        if (bus2.imem_req) bus2.imem_rdata <= memWord(bus2.imem_addr);
    end

    // Reference model: a plain queue of fetched words plus the one read that
    // is on its way back from memory.
    ent_t        mQ [$];
    logic [31:0] mFetchPc;
    logic [31:0] mInflightPc;
    logic        mInflight;

    function automatic logic expReq();
        if (!rst_n) return 1'b0;
        return ((mQ.size() + int'(mInflight)) < int'(DEPTH)) || bus.redirect;
    endfunction

    function automatic logic [31:0] expAddr();
        return bus.redirect ? bus.target : mFetchPc;
    endfunction

    function automatic logic [31:0] expInstr();
        return (mQ.size() != 0) ? mQ[0].instr : NOP_INSTR;
    endfunction

    function automatic logic [31:0] expPc4();
        if (!rst_n) return 32'h0;
        return (mQ.size() != 0) ? mQ[0].pc4 : mFetchPc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mQ.delete();
            mFetchPc    <= RESET_PC;
            mInflight   <= 1'b0;
            mInflightPc <= 32'h0;
        end else begin
            mInflight <= expReq();
            if (expReq()) begin
                mInflightPc <= expAddr();
                mFetchPc    <= expAddr() + 32'd4;
            end
            if (bus.redirect) begin
                mQ.delete();
            end else begin
                if (mQ.size() != 0 && !bus.stall) void'(mQ.pop_front());
                if (mInflight) mQ.push_back({memWord(mInflightPc), mInflightPc + 32'd4});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, mid-period, the first DUT must agree with the model.
    always @(negedge clk) begin
        checkOutput("model_imem_req", 32'(bus.imem_req), 32'(expReq()));
        if (expReq()) checkOutput("model_imem_addr", bus.imem_addr, expAddr());
        checkOutput("model_instr_valid", 32'(bus.instr_valid), 32'(mQ.size() != 0));
        checkOutput("model_instr", bus.instr, expInstr());
        checkOutput("model_pc_plus_four", bus.pc_plus_four, expPc4());
        checkOutput("model_occupancy", 32'(bus.occupancy), 32'(mQ.size()));
    end

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] t);
        @(posedge clk);
        #1;
        bus.stall    = s;
        bus.redirect = r;
        bus.target   = t;
    endtask

    task automatic doReset();
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        bus.target   = 32'h0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] addrTab [4];
    logic [31:0] pc4Tab  [4];

    initial begin
        total = 0;
        bad   = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        bus.stall     = 1'b0;
        bus.redirect  = 1'b0;
        bus.target    = 32'h0;
        bus2.stall    = 1'b0;
        bus2.redirect = 1'b0;
        bus2.target   = 32'h0;
        addrTab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        pc4Tab  = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'h0);
        checkOutput("rst_instr", bus.instr, NOP_INSTR);
        checkOutput("rst_pc4", bus.pc_plus_four, 32'h0);
        checkOutput("rst_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("rst_occ", 32'(bus.occupancy), 32'h0);

        $display("[TB] streaming fetch");
        doReset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("t1_req", 32'(bus.imem_req), 32'h1);
            checkOutput("t1_addr", bus.imem_addr, 32'(4 * c));
            checkOutput("t1_valid", 32'(bus.instr_valid), 32'(c >= 2));
            if (c >= 2) begin
                checkOutput("t1_pc4", bus.pc_plus_four, 32'(4 * (c - 1)));
                checkOutput("t1_instr", bus.instr, memWord(32'(4 * (c - 2))));
            end
            checkOutput("t1_occ_le1", 32'(bus.occupancy <= 1), 32'h1);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end

        $display("[TB] stall until full, then drain");
        doReset();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c == 4) checkOutput("t2_req_drop", 32'(bus.imem_req), 32'h0);
            if (c == 11) begin
                checkOutput("t2_full_occ", 32'(bus.occupancy), 32'(DEPTH));
                checkOutput("t2_full_req", 32'(bus.imem_req), 32'h0);
                checkOutput("t2_hold_pc4", bus.pc_plus_four, 32'h4);
                checkOutput("t2_hold_instr", bus.instr, memWord(32'h0));
            end
            if (c >= 12) begin
                checkOutput("t2_drain_valid", 32'(bus.instr_valid), 32'h1);
                checkOutput("t2_drain_pc4", bus.pc_plus_four, 32'(4 * (c - 11)));
            end
            applyStimulus((c + 1 >= 2) && (c + 1 <= 11), 1'b0, 32'h0);
        end

        $display("[TB] redirect with queued entries, then redirect under stall");
        doReset();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c == 4) begin
                checkOutput("t3_pre_occ", 32'(bus.occupancy), 32'h3);
                checkOutput("t3_redir_req", 32'(bus.imem_req), 32'h1);
                checkOutput("t3_redir_addr", bus.imem_addr, 32'h0000_0100);
            end
            if (c == 5) begin
                checkOutput("t3_flush_occ", 32'(bus.occupancy), 32'h0);
                checkOutput("t3_flush_valid", 32'(bus.instr_valid), 32'h0);
            end
            if (c == 6) begin
                checkOutput("t3_tgt_instr", bus.instr, memWord(32'h0000_0100));
                checkOutput("t3_tgt_pc4", bus.pc_plus_four, 32'h0000_0104);
            end
            if (c == 7) checkOutput("t3_next_pc4", bus.pc_plus_four, 32'h0000_0108);
            if (c == 14) begin
                checkOutput("t4_full_occ", 32'(bus.occupancy), 32'(DEPTH));
                checkOutput("t4_redir_req", 32'(bus.imem_req), 32'h1);
                checkOutput("t4_redir_addr", bus.imem_addr, 32'h0000_0200);
            end
            if (c == 15) begin
                checkOutput("t4_flush_occ", 32'(bus.occupancy), 32'h0);
                checkOutput("t4_flush_valid", 32'(bus.instr_valid), 32'h0);
            end
            if (c == 16) begin
                checkOutput("t4_tgt_instr", bus.instr, memWord(32'h0000_0200));
                checkOutput("t4_tgt_pc4", bus.pc_plus_four, 32'h0000_0204);
            end
            applyStimulus((c + 1 == 2) || (c + 1 == 3) || (c + 1 >= 8),
                          (c + 1 == 4) || (c + 1 == 14),
                          (c + 1 == 4) ? 32'h0000_0100 : 32'h0000_0200);
        end

        $display("[TB] asynchronous reset mid-stream");
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(c + 1 >= 2, 1'b0, 32'h0);
        end
        #2;
        checkOutput("t6_pre_occ", 32'(bus.occupancy), 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_req", 32'(bus.imem_req), 32'h0);
        checkOutput("t6_async_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("t6_async_occ", 32'(bus.occupancy), 32'h0);
        checkOutput("t6_async_instr", bus.instr, NOP_INSTR);
        checkOutput("t6_async_pc4", bus.pc_plus_four, 32'h0);
        @(posedge clk);
        #1;
        bus.stall = 1'b0;
        rst_n     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("t6_restart_addr", bus.imem_addr, RESET_PC);
            if (c == 1) checkOutput("t6_stale_dropped", 32'(bus.occupancy), 32'h0);
            if (c == 2) begin
                checkOutput("t6_first_instr", bus.instr, memWord(RESET_PC));
                checkOutput("t6_first_pc4", bus.pc_plus_four, RESET_PC + 32'd4);
            end
            applyStimulus(1'b0, 1'b0, 32'h0);
        end

        $display("[TB] address wrap-around");
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) checkOutput("t5_addr", bus2.imem_addr, addrTab[c]);
            if (c >= 2) begin
                checkOutput("t5_valid", 32'(bus2.instr_valid), 32'h1);
                checkOutput("t5_pc4", bus2.pc_plus_four, pc4Tab[c - 2]);
                checkOutput("t5_instr", bus2.instr, memWord(addrTab[c - 2]));
                checkOutput("t5_occ", 32'(bus2.occupancy), 32'h1);
            end
            if (c == 0) checkOutput("t5_req", 32'(bus2.imem_req), 32'h1);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
